muldiv_iter: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M multiply–divide unit for the EX stage of the RISC-V pipeline.
- Takes over the M-extension codes from the single-cycle combinational ALU.
- Adds correct high-half products, DIVU, the RISC-V divide-by-zero and overflow rules, valid/ready handshakes and flush support.
- The pipeline stalls on BUSY while an operation iterates.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_signfix.sv | 26 ++
 rtl/muldiv_iter.sv | 156 +++++++++++++++
 tb/tb_muldiv_iter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM state encoding and op-decoding helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_high_half(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            IN_VALID;
  logic            IN_READY;
  logic [2:0]      OP;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] RESULT;
  logic            BUSY;

  modport master (
    output IN_VALID, OP, DATA1, DATA2, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, BUSY
  );

  modport slave (
    input  IN_VALID, OP, DATA1, DATA2, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, BUSY
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation of two XLEN words, either independently
// (operand magnitudes, quotient/remainder) or as one 2*XLEN word (product).
module muldiv_signfix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic            neg_hi,
  input  logic            neg_lo,
  input  logic            wide,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic neg_lo_eff;
  logic hi_carry;

  // In wide mode the +1 of the negation ripples into the high word only when the low word is zero.
  always_comb begin
    neg_lo_eff = wide ? neg_hi : neg_lo;
    hi_carry   = wide ? (lo_in == '0) : 1'b1;
    lo_out     = neg_lo_eff ? (~lo_in + XLEN'(1)) : lo_in;
    hi_out     = neg_hi ? (~hi_in + XLEN'(hi_carry)) : hi_in;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, RISC-V divide-by-zero/overflow rules, valid/ready and flush.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic     CLK,
  input logic     RESET,
  input logic     FLUSH,
  muldiv_if.slave bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic              neg_a_q, neg_b_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   result_q;
  logic              out_valid_q;

  logic              accept, div_by_zero, div_ovf, special, last_iter;
  logic [XLEN-1:0]   mag_a_in, mag_b_in, special_result;
  logic [XLEN:0]     add_sum, rem_shift;
  logic [XLEN+1:0]   rem_diff;
  logic [XLEN-1:0]   fix_hi_in, fix_hi, fix_lo, fix_result;
  logic              fix_neg_hi, fix_neg_lo;

  muldiv_signfix #(.XLEN(XLEN)) u_in_fix (
    .hi_in  (bus.DATA1),
    .lo_in  (bus.DATA2),
    .neg_hi (is_signed_a(bus.OP) && bus.DATA1[XLEN-1]),
    .neg_lo (is_signed_b(bus.OP) && bus.DATA2[XLEN-1]),
    .wide   (1'b0),
    .hi_out (mag_a_in),
    .lo_out (mag_b_in)
  );

  // Divides keep the remainder in rem_q and the quotient in the low accumulator half.
  always_comb begin
    fix_hi_in  = is_div(op_q) ? rem_q : acc_q[2*XLEN-1:XLEN];
    fix_neg_lo = neg_a_q ^ neg_b_q;
    fix_neg_hi = is_div(op_q) ? neg_a_q : fix_neg_lo;
  end

  muldiv_signfix #(.XLEN(XLEN)) u_out_fix (
    .hi_in  (fix_hi_in),
    .lo_in  (acc_q[XLEN-1:0]),
    .neg_hi (fix_neg_hi),
    .neg_lo (fix_neg_lo),
    .wide   (!is_div(op_q)),
    .hi_out (fix_hi),
    .lo_out (fix_lo)
  );

  always_comb begin
    accept         = bus.IN_VALID && (state_q == IDLE) && !FLUSH;
    div_by_zero    = is_div(bus.OP) && (bus.DATA2 == '0);
    div_ovf        = ((bus.OP == OP_DIV) || (bus.OP == OP_REM)) &&
                     (bus.DATA1 == MIN_NEG) && (bus.DATA2 == '1);
    special        = div_by_zero || div_ovf;
    special_result = div_by_zero ? (is_rem(bus.OP) ? bus.DATA1 : '1)
                                 : (is_rem(bus.OP) ? '0 : bus.DATA1);
    last_iter      = (cnt_q == CNT_W'(XLEN - 1));
    add_sum        = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    rem_shift      = {rem_q, acc_q[XLEN-1]};
    rem_diff       = {1'b0, rem_shift} - {2'b00, mag_b_q};
    if (is_div(op_q))
      fix_result = is_rem(op_q) ? fix_hi : fix_lo;
    else
      fix_result = is_high_half(op_q) ? fix_hi : fix_lo;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (last_iter) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (FLUSH) state_d = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: operand capture at accept, one iteration per CALC cycle, result write in FIX.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q       <= '0;
      op_q        <= OP_MUL;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      mag_b_q     <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (FLUSH) begin
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= bus.OP;
            neg_a_q <= is_signed_a(bus.OP) && bus.DATA1[XLEN-1];
            neg_b_q <= is_signed_b(bus.OP) && bus.DATA2[XLEN-1];
            mag_b_q <= mag_b_in;
            cnt_q   <= '0;
            rem_q   <= '0;
            acc_q   <= {{XLEN{1'b0}}, mag_a_in};
            if (special) begin
              result_q    <= special_result;
              out_valid_q <= 1'b1;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div(op_q)) begin
            if (!rem_diff[XLEN+1]) begin
              rem_q            <= rem_diff[XLEN-1:0];
              acc_q[XLEN-1:0]  <= {acc_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q            <= rem_shift[XLEN-1:0];
              acc_q[XLEN-1:0]  <= {acc_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_q <= {add_sum, acc_q[XLEN-1:1]};
          end
        end
        FIX: begin
          result_q    <= fix_result;
          out_valid_q <= 1'b1;
        end
        DONE: if (bus.OUT_READY) out_valid_q <= 1'b0;
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.IN_READY  = (state_q == IDLE);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.OUT_VALID = out_valid_q;
  assign bus.RESULT    = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed vectors on a 32-bit and an 8-bit instance,
// expected results queued at issue time and checked by per-instance output monitors.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32, rst8, flush32, flush8;
  muldiv_if #(.XLEN(32)) bus32();
  muldiv_if #(.XLEN(8))  bus8();

  muldiv_iter #(.XLEN(32)) dut32 (.CLK(clk), .RESET(rst32), .FLUSH(flush32), .bus(bus32));
  muldiv_iter #(.XLEN(8))  dut8  (.CLK(clk), .RESET(rst8),  .FLUSH(flush8),  .bus(bus8));

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q32[$];
  logic [7:0]  exp_q8[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitors: a transfer happens on the edge after valid && ready is seen here.
  initial forever begin
    @(negedge clk); #1;
    if (bus32.OUT_VALID && bus32.OUT_READY) begin
      if (exp_q32.size() == 0) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL unexpected_output32: got 0x%0h, expected no output", bus32.RESULT);
      end else checkOutput("result32", bus32.RESULT, exp_q32.pop_front());
    end
  end

  initial forever begin
    @(negedge clk); #1;
    if (bus8.OUT_VALID && bus8.OUT_READY) begin
      if (exp_q8.size() == 0) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL unexpected_output8: got 0x%0h, expected no output", bus8.RESULT);
      end else checkOutput("result8", bus8.RESULT, exp_q8.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Presents one request and returns #1 after the accept edge, scrambling the operands afterwards.
  task automatic issueOp32(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2);
    @(negedge clk);
    bus32.IN_VALID = 1'b1;
    bus32.OP       = op;
    bus32.DATA1    = d1;
    bus32.DATA2    = d2;
    @(posedge clk); #1;
    bus32.IN_VALID = 1'b0;
    bus32.OP       = ~op;
    bus32.DATA1    = ~d1;
    bus32.DATA2    = d1;
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] expv, input int exp_lat);
    int lat;
    bit busy_ok;
    exp_q32.push_back(expv);
    issueOp32(op, d1, d2);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus32.OUT_VALID && lat < 100) begin
      if (bus32.IN_READY || !bus32.BUSY) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_busy"}, 64'(busy_ok), 64'd1);
    lat = 0;
    while (!bus32.IN_READY && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) checkOutput({name, "_return_idle_timeout"}, 64'(bus32.IN_READY), 64'd1);
  endtask

  initial begin
    int lat;
    int valid_seen;
    rst32 = 1'b1; rst8 = 1'b1; flush32 = 1'b0; flush8 = 1'b0;
    bus32.IN_VALID = 1'b0; bus32.OP = OP_MUL; bus32.DATA1 = '0; bus32.DATA2 = '0; bus32.OUT_READY = 1'b1;
    bus8.IN_VALID  = 1'b0; bus8.OP  = OP_MUL; bus8.DATA1  = '0; bus8.DATA2  = '0; bus8.OUT_READY  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready",  64'(bus32.IN_READY),  64'd1);
    checkOutput("reset_out_valid", 64'(bus32.OUT_VALID), 64'd0);
    checkOutput("reset_busy",      64'(bus32.BUSY),      64'd0);
    checkOutput("reset_result",    64'(bus32.RESULT),    64'd0);
    checkOutput("reset8_in_ready", 64'(bus8.IN_READY),   64'd1);
    @(negedge clk);
    rst32 = 1'b0; rst8 = 1'b0;

    applyStimulus("mul",       OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    applyStimulus("mulh",      OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    applyStimulus("mulhu",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    applyStimulus("mulhsu",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    applyStimulus("div",       OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    applyStimulus("rem",       OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    applyStimulus("divu",      OP_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33);
    applyStimulus("remu",      OP_REMU,   32'hFFFFFFF9, 32'd2,        32'd1,        33);
    applyStimulus("div_zero",  OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 0);
    applyStimulus("remu_zero", OP_REMU,   32'd5,        32'd0,        32'd5,        0);
    applyStimulus("div_ovf",   OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    applyStimulus("rem_ovf",   OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0);

    // Backpressure: result must hold while the consumer stalls.
    @(negedge clk);
    bus32.OUT_READY = 1'b0;
    exp_q32.push_back(32'd42);
    issueOp32(OP_MUL, 32'd6, 32'd7);
    lat = 0;
    while (!bus32.OUT_VALID && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp_latency", 64'(lat), 64'd33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checkOutput("bp_hold_valid",  64'(bus32.OUT_VALID), 64'd1);
      checkOutput("bp_hold_result", 64'(bus32.RESULT),    64'd42);
    end
    @(negedge clk);
    bus32.OUT_READY = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_in_ready",  64'(bus32.IN_READY),  64'd1);
    checkOutput("bp_release_out_valid", 64'(bus32.OUT_VALID), 64'd0);

    // Flush at t0+10 of a divide: back to IDLE, result kept, never a valid pulse.
    issueOp32(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush32 = 1'b1;
    @(posedge clk); #1;
    checkOutput("flush_in_ready", 64'(bus32.IN_READY), 64'd1);
    checkOutput("flush_busy",     64'(bus32.BUSY),     64'd0);
    checkOutput("flush_result",   64'(bus32.RESULT),   64'd42);
    @(negedge clk);
    flush32 = 1'b0;
    valid_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.OUT_VALID) valid_seen++;
    end
    checkOutput("flush_no_valid", 64'(valid_seen), 64'd0);

    // Reset at t0+5 of a multiply.
    issueOp32(OP_MUL, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst32 = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_in_ready",  64'(bus32.IN_READY),  64'd1);
    checkOutput("midrst_out_valid", 64'(bus32.OUT_VALID), 64'd0);
    checkOutput("midrst_busy",      64'(bus32.BUSY),      64'd0);
    checkOutput("midrst_result",    64'(bus32.RESULT),    64'd0);
    @(negedge clk);
    rst32 = 1'b0;

    // Flush together with a request in IDLE must not accept it.
    @(negedge clk);
    bus32.IN_VALID = 1'b1; bus32.OP = OP_MUL; bus32.DATA1 = 32'd2; bus32.DATA2 = 32'd3;
    flush32 = 1'b1;
    @(posedge clk); #1;
    checkOutput("flush_req_busy", 64'(bus32.BUSY), 64'd0);
    @(negedge clk);
    bus32.IN_VALID = 1'b0;
    flush32 = 1'b0;

    // 8-bit instance: 3 x 0xFD -> 0xF7 after XLEN+1 edges.
    exp_q8.push_back(8'hF7);
    @(negedge clk);
    bus8.IN_VALID = 1'b1; bus8.OP = OP_MUL; bus8.DATA1 = 8'd3; bus8.DATA2 = 8'hFD;
    @(posedge clk); #1;
    bus8.IN_VALID = 1'b0; bus8.DATA1 = 8'h55; bus8.DATA2 = 8'hAA;
    lat = 0;
    while (!bus8.OUT_VALID && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("mul8_latency", 64'(lat), 64'd9);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queue32_drained", 64'(exp_q32.size()), 64'd0);
    checkOutput("queue8_drained",  64'(exp_q8.size()),  64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
